rs232_frame_tx: RTL and testbench

Parametrised RS232 transmitter that serialises one DATA_W-bit sample into NCHUNK tagged UART characters per frame on a single TX line. It is the next generation of the fixed 12-bit/2-character/9600-baud sender that feeds the LabVIEW host. It adds a valid/ready sample handshake, configurable baud divisor, chunking, parity mode, stop bits and inter-character gap, and a frame-done pulse. It sits between the measurement datapath and the board TX pin.

---
 rtl/rs232_frame_tx.sv | 145 ++++++++++++++
 tb/tb_rs232_frame_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rs232_frame_tx.sv
// RS232 frame transmitter: one DATA_W-bit sample is sent as NCHUNK tagged UART
// characters (start, tag, payload, optional parity, stop bits, idle gap).
module rs232_frame_tx #(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_W    = 12,
  parameter int CHUNK_W   = 7,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int NCHUNK  = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int TAG_W   = (NCHUNK <= 1) ? 1 : $clog2(NCHUNK);
  localparam int CHAR_W  = TAG_W + CHUNK_W;
  localparam int PAD_W   = NCHUNK * CHUNK_W;
  localparam int BIT_MAX = (GAP_BITS > CHAR_W) ? GAP_BITS : CHAR_W;
  localparam int BIT_CW  = $clog2(BIT_MAX);
  localparam int BAUD_CW = $clog2(CLK_DIV);

  if (CLK_DIV < 2 || DATA_W < 1 || CHUNK_W < 1 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || GAP_BITS < 0) begin : g_bad_param
    $error("rs232_frame_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP} state_t;

  state_t             state, state_n;
  logic [BAUD_CW-1:0] baud_cnt, baud_n;
  logic [BIT_CW-1:0]  bit_cnt, bit_n;
  logic [TAG_W-1:0]   k, k_n;
  logic [PAD_W-1:0]   cap, cap_n;
  logic [CHUNK_W-1:0] chunk_n;
  logic [CHAR_W-1:0]  char_n;
  logic               bit_end, done_n, tx_n;

  assign bit_end        = (baud_cnt == BAUD_CW'(CLK_DIV - 1));
  assign sample_ready_o = (state == S_IDLE);
  assign busy_o         = (state != S_IDLE);

  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud_cnt + 1'b1;
    bit_n   = bit_cnt;
    k_n     = k;
    cap_n   = cap;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        k_n    = '0;
        if (sample_valid_i) begin
          state_n = S_START;
          cap_n   = PAD_W'(sample_i);
        end
      end
      S_START: if (bit_end) begin
        state_n = S_DATA;
        bit_n   = '0;
      end
      S_DATA: if (bit_end) begin
        if (bit_cnt == BIT_CW'(CHAR_W - 1)) begin
          bit_n   = '0;
          state_n = (PARITY != 0) ? S_PAR : S_STOP;
        end else bit_n = bit_cnt + 1'b1;
      end
      S_PAR: if (bit_end) begin
        state_n = S_STOP;
        bit_n   = '0;
      end
      S_STOP: if (bit_end) begin
        if (bit_cnt == BIT_CW'(STOP_BITS - 1)) begin
          bit_n = '0;
          if (k == TAG_W'(NCHUNK - 1)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else if (GAP_BITS == 0) begin
            state_n = S_START;
            k_n     = k + 1'b1;
          end else state_n = S_GAP;
        end else bit_n = bit_cnt + 1'b1;
      end
      S_GAP: if (bit_end) begin
        if (bit_cnt == BIT_CW'(GAP_BITS - 1)) begin
          bit_n   = '0;
          state_n = S_START;
          k_n     = k + 1'b1;
        end else bit_n = bit_cnt + 1'b1;
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bit_n   = '0;
        k_n     = '0;
      end
    endcase
  end

  // tx is registered, so the line level is derived from the next state/counters
  always_comb begin
    chunk_n = '0;
    for (int j = 0; j < NCHUNK; j++)
      if (k_n == TAG_W'(j)) chunk_n = cap_n[j*CHUNK_W +: CHUNK_W];
    char_n = {chunk_n, k_n};
    tx_n   = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:
        for (int i = 0; i < CHAR_W; i++)
          if (bit_n == BIT_CW'(i)) tx_n = char_n[i];
      S_PAR:   tx_n = (^char_n) ^ (PARITY == 2);
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      k            <= '0;
      cap          <= '1;
      tx_o         <= 1'b1;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      baud_cnt     <= baud_n;
      bit_cnt      <= bit_n;
      k            <= k_n;
      cap          <= cap_n;
      tx_o         <= tx_n;
      frame_done_o <= done_n;
    end
  end

endmodule

// File: tb/tb_rs232_frame_tx.sv
// Directed bench: three transmitter configurations, line sampled mid bit-time
// and compared against hand-derived bit strings (index 0 = first bit-time).
module tb_rs232_frame_tx;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0][15:0] smp;
  logic [2:0]       vld, rdy, tx, bsy, dn;
  int               checks = 0;
  int               passes = 0;
  logic [63:0]      got;

  always #5 clk = ~clk;

  // 0: default with CLK_DIV=4, 1: odd parity, 2: 16-bit/6-bit chunks, 2 stops, no gap
  rs232_frame_tx #(.CLK_DIV(4)) u_a (
    .clk(clk), .rst(rst), .sample_i(smp[0][11:0]), .sample_valid_i(vld[0]),
    .sample_ready_o(rdy[0]), .tx_o(tx[0]), .busy_o(bsy[0]), .frame_done_o(dn[0]));
  rs232_frame_tx #(.CLK_DIV(4), .PARITY(2)) u_b (
    .clk(clk), .rst(rst), .sample_i(smp[1][11:0]), .sample_valid_i(vld[1]),
    .sample_ready_o(rdy[1]), .tx_o(tx[1]), .busy_o(bsy[1]), .frame_done_o(dn[1]));
  rs232_frame_tx #(.CLK_DIV(4), .DATA_W(16), .CHUNK_W(6), .STOP_BITS(2), .GAP_BITS(0)) u_d (
    .clk(clk), .rst(rst), .sample_i(smp[2]), .sample_valid_i(vld[2]),
    .sample_ready_o(rdy[2]), .tx_o(tx[2]), .busy_o(bsy[2]), .frame_done_o(dn[2]));

  function automatic logic [63:0] s2b(input string s);
    logic [63:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[i] = (s[i] == 8'h31);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // call at 1ns after an edge; returns 1ns after the acceptance edge
  task automatic send(input int d, input logic [15:0] v);
    smp[d] = v;
    vld[d] = 1'b1;
    @(posedge clk); #1;
    vld[d] = 1'b0;
    chk("start_low", 64'(tx[d]), 64'd0);
    chk("busy_at_start", 64'(bsy[d]), 64'd1);
  endtask

  // call 1ns after the acceptance edge; ends 1ns after the edge following the frame
  task automatic collect(input int d, input int n, output logic [63:0] bits);
    bits = '0;
    for (int b = 0; b < n; b++) begin
      repeat (2) @(posedge clk); #1;
      bits[b] = tx[d];
      repeat (2) @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; vld = '0; smp = '0;
    repeat (3) @(posedge clk); #1;
    chk("reset_tx", 64'(tx), 64'b111);
    chk("reset_ready", 64'(rdy), 64'b111);
    chk("reset_busy", 64'(bsy), 64'b000);
    chk("reset_done", 64'(dn), 64'b000);
    rst = 1'b0;
    @(posedge clk); #1;

    send(0, 16'h0ABC);
    collect(0, 23, got);
    chk("abc_bits", got, s2b("00001111001101101010001"));
    chk("abc_done_92", 64'(dn[0]), 64'd1);
    chk("abc_ready_92", 64'(rdy[0]), 64'd1);
    @(posedge clk); #1;
    chk("abc_done_one_cycle", 64'(dn[0]), 64'd0);

    send(1, 16'h0001);
    collect(1, 23, got);
    chk("odd_parity_bits", got, s2b("00100000001101000000001"));
    chk("odd_done", 64'(dn[1]), 64'd1);

    send(0, 16'h0001);
    collect(0, 23, got);
    chk("even_parity_bits", got, s2b("00100000011101000000011"));

    send(2, 16'hFFFF);
    collect(2, 36, got);
    chk("wide_bits", got, s2b("000111111011010111111111001111100111"));
    chk("wide_done", 64'(dn[2]), 64'd1);

    // valid held high, sample changed mid-frame
    smp[0] = 16'h0123; vld[0] = 1'b1;
    @(posedge clk); #1;
    chk("hold_start_low", 64'(tx[0]), 64'd0);
    smp[0] = 16'h0456;
    collect(0, 23, got);
    chk("hold_first_bits", got, s2b("00110001011101010000001"));
    chk("hold_done", 64'(dn[0]), 64'd1);
    chk("hold_ready", 64'(rdy[0]), 64'd1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    chk("b2b_start_low", 64'(tx[0]), 64'd0);
    chk("b2b_busy", 64'(bsy[0]), 64'd1);
    chk("b2b_done_low", 64'(dn[0]), 64'd0);
    collect(0, 23, got);
    chk("b2b_second_bits", got, s2b("00011010101101000100001"));

    // valid pulse while busy must be ignored
    send(0, 16'h0ABC);
    fork
      collect(0, 23, got);
      begin
        repeat (10) @(posedge clk); #2;
        smp[0] = 16'h0555; vld[0] = 1'b1;
        @(posedge clk); #2;
        vld[0] = 1'b0;
      end
    join
    chk("busy_pulse_bits", got, s2b("00001111001101101010001"));
    repeat (3) @(posedge clk); #1;
    chk("busy_pulse_idle_ready", 64'(rdy[0]), 64'd1);
    chk("busy_pulse_idle_tx", 64'(tx[0]), 64'd1);
    chk("busy_pulse_idle_busy", 64'(bsy[0]), 64'd0);

    // reset during data bits of character 1
    send(0, 16'h0ABC);
    repeat (60) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_tx", 64'(tx[0]), 64'd1);
    chk("midrst_ready", 64'(rdy[0]), 64'd1);
    chk("midrst_busy", 64'(bsy[0]), 64'd0);
    chk("midrst_done", 64'(dn[0]), 64'd0);
    repeat (2) @(posedge clk); #1;
    chk("midrst_line_high", 64'(tx[0]), 64'd1);
    chk("midrst_no_done", 64'(dn[0]), 64'd0);
    send(0, 16'h0123);
    collect(0, 23, got);
    chk("after_rst_bits", got, s2b("00110001011101010000001"));
    chk("after_rst_done", 64'(dn[0]), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
